adc_acq_scheduler: RTL and testbench
====================================

ADC_ACQ_SCHEDULER -- requirements
Module: adc_acq_scheduler

Interface
REQ-001 SHALL have parameters: DIV_WIDTH, default 16, conversion-period counter width; CNV_HIGH, default 2, CNV pulse width in clk cycles; BUSY_TIMEOUT, default 64, max cycles waiting for ADC busy rise.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous active-low reset
- enable  in  1  periodic conversions on
- cnv_div  in  DIV_WIDTH  conversion period in clk cycles
- cfg_req  in  1  register-write request, held until cfg_ack
- cfg_cmd  in  24  register command
- cfg_ack  out  1  one-cycle pulse, write complete
- cnv  out  1  ADC convert strobe
- adc_busy  in  1  ADC busy
- start_acq  out  1  one-cycle pulse to SPI controller
- start_reg_wrt  out  1  one-cycle pulse to SPI controller
- reg_cmd  out  24  latched command to SPI controller
- acq_done  in  1  SPI controller readout complete pulse
- reg_wrt_done  in  1  SPI controller write complete pulse
- cnv_data  in  32  SPI controller readout data
- m_data  out  32  sample output
- m_valid  out  1  sample valid
- m_ready  in  1  sink ready
- overrun  out  1  sticky, missed tick or dropped sample
- timeout  out  1  sticky, busy never rose
- err_clr  in  1  clears overrun and timeout

Function
REQ-003 SHALL contain a period counter, running only while enable=1, counting 0..N-1 with N=max(cnv_div,2), and producing a tick when the count is 0.
REQ-004 SHALL restart the counter at 0 on every enable rising edge, so the first tick occurs in the cycle after enable is sampled high.
REQ-005 SHALL implement states IDLE, CNV, WAIT_RISE, WAIT_FALL, ACQ, REG_WR.
REQ-006 IDLE: on tick go to CNV; otherwise on cfg_req go to REG_WR; a tick wins over a cfg_req in the same cycle.
REQ-007 CNV: cnv=1 for exactly CNV_HIGH cycles, then go to WAIT_RISE; cnv=0 in all other states.
REQ-008 WAIT_RISE: on adc_busy=1 go to WAIT_FALL; after BUSY_TIMEOUT cycles without busy, set timeout and return to IDLE with no start_acq.
REQ-009 WAIT_FALL: on adc_busy=0, pulse start_acq for 1 cycle in the next cycle and go to ACQ.
REQ-010 ACQ: on acq_done go to IDLE and capture cnv_data into m_data with m_valid=1 in the following cycle.
REQ-011 REG_WR: on entry, latch cfg_cmd into reg_cmd and pulse start_reg_wrt for 1 cycle; on reg_wrt_done pulse cfg_ack for 1 cycle and return to IDLE.
REQ-012 A tick arriving in any state other than IDLE SHALL be dropped, set overrun, and leave the counter free-running.
REQ-013 The output register SHALL hold m_data stable while m_valid=1 and m_ready=0, and clear m_valid on a cycle with m_valid=1 and m_ready=1.
REQ-014 On capture with m_valid=1 and m_ready=0, the new sample SHALL be dropped and overrun set; with m_ready=1 in the same cycle the new sample SHALL replace the old one and m_valid stay 1.
REQ-015 When enable drops mid-sequence, the current sequence SHALL complete normally and no new ticks occur.
REQ-016 err_clr SHALL clear overrun and timeout; a set event in the same cycle as err_clr wins.
REQ-017 acq_done or reg_wrt_done received outside ACQ or REG_WR respectively SHALL be ignored.

Reset
REQ-018 With resetn=0, the block SHALL asynchronously return to IDLE, zero the counter, and drive cnv, start_acq, start_reg_wrt, cfg_ack, m_valid, overrun and timeout to 0, with reg_cmd and m_data at 0.
REQ-019 After resetn deasserts, the block SHALL begin operation on the first rising clk edge, with no spurious pulses.
REQ-020 Reset asserted mid-sequence SHALL abort the sequence with no cfg_ack or start_acq issued.

Verification
REQ-021 enable=1, cnv_div=100, ADC model busy 20 cycles -> cnv every 100 cycles, 2 cycles wide; one start_acq per busy fall; m_data=0x8BADF00D matches pattern.
REQ-022 cfg_req with cfg_cmd=0x140001 while enable=0 -> reg_cmd=0x140001, single start_reg_wrt, cfg_ack 1 cycle after reg_wrt_done.
REQ-023 cfg_req in the same cycle as a tick -> conversion first; write issued after acq_done; cfg_ack once.
REQ-024 cnv_div=10 with readout longer than 10 cycles -> overrun=1, every other tick skipped; err_clr -> overrun=0.
REQ-025 m_ready=0 across two acquisitions -> first sample held, second dropped, overrun=1.
REQ-026 adc_busy tied 0 -> timeout=1 after 64 cycles in WAIT_RISE, no start_acq; resetn pulse mid-ACQ -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/adc_acq_scheduler.sv
`timescale 1ns/1ps
// adc_acq_scheduler: paces ADC conversions, hands readout and register writes to an SPI controller
module adc_acq_scheduler #(
    parameter int DIV_WIDTH    = 16,
    parameter int CNV_HIGH     = 2,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] cnv_div,
    input  logic                 cfg_req,
    input  logic [23:0]          cfg_cmd,
    output logic                 cfg_ack,
    output logic                 cnv,
    input  logic                 adc_busy,
    output logic                 start_acq,
    output logic                 start_reg_wrt,
    output logic [23:0]          reg_cmd,
    input  logic                 acq_done,
    input  logic                 reg_wrt_done,
    input  logic [31:0]          cnv_data,
    output logic [31:0]          m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    output logic                 timeout,
    input  logic                 err_clr
);
    localparam int TMAX = CNV_HIGH > BUSY_TIMEOUT ? CNV_HIGH : BUSY_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, CNV, WAIT_RISE, WAIT_FALL, ACQ, REG_WR} state_e;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, period;
    logic                 en_q, tick, busy_to;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic                 start_acq_q, start_acq_d, start_reg_wrt_q, start_reg_wrt_d;
    logic                 cfg_ack_q, cfg_ack_d, m_valid_q, m_valid_d;
    logic                 overrun_q, overrun_d, timeout_q, timeout_d;
    logic                 capture, accept;
    logic [23:0]          reg_cmd_q, reg_cmd_d;
    logic [31:0]          m_data_q, m_data_d;

    // period counter restarts on every enable rising edge and ticks at count 0
    always_comb begin
        period = cnv_div < DIV_WIDTH'(2) ? DIV_WIDTH'(2) : cnv_div;
        tick   = enable && en_q && cnt_q == '0;
        cnt_d  = (!enable || !en_q || cnt_q >= period - 1'b1) ? '0 : cnt_q + 1'b1;
    end

    // counter and enable-edge registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= enable;
        end
    end

    // state register with per-state timer cleared on every transition
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // next-state logic; a tick beats a pending register write, and the request
    // still visible during the acknowledge cycle is not re-served
    always_comb begin
        busy_to = state_q == WAIT_RISE && !adc_busy && tmr_q == TW'(BUSY_TIMEOUT - 1);
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = tick ? CNV : (cfg_req && !cfg_ack_q) ? REG_WR : IDLE;
            CNV:       state_d = tmr_q == TW'(CNV_HIGH - 1) ? WAIT_RISE : CNV;
            WAIT_RISE: state_d = adc_busy ? WAIT_FALL : busy_to ? IDLE : WAIT_RISE;
            WAIT_FALL: state_d = adc_busy ? WAIT_FALL : ACQ;
            ACQ:       state_d = acq_done ? IDLE : ACQ;
            REG_WR:    state_d = reg_wrt_done ? IDLE : REG_WR;
            default:   state_d = IDLE;
        endcase
        tmr_d = state_d != state_q ? '0 : tmr_q + 1'b1;
    end

    // outputs: strobe decode, pulse requests, sample hand-off and sticky errors
    always_comb begin
        cnv             = state_q == CNV;
        start_acq_d     = state_q == WAIT_FALL && !adc_busy;
        start_reg_wrt_d = state_q == IDLE && state_d == REG_WR;
        cfg_ack_d       = state_q == REG_WR && reg_wrt_done;
        reg_cmd_d       = start_reg_wrt_d ? cfg_cmd : reg_cmd_q;
        capture         = state_q == ACQ && acq_done;
        accept          = !m_valid_q || m_ready;
        m_valid_d       = capture || (m_valid_q && !m_ready);
        m_data_d        = capture && accept ? cnv_data : m_data_q;
        overrun_d       = (tick && state_q != IDLE) || (capture && !accept) || (overrun_q && !err_clr);
        timeout_d       = busy_to || (timeout_q && !err_clr);
    end

    // registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_acq_q     <= 1'b0;
            start_reg_wrt_q <= 1'b0;
            cfg_ack_q       <= 1'b0;
            reg_cmd_q       <= '0;
            m_valid_q       <= 1'b0;
            m_data_q        <= '0;
            overrun_q       <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            start_acq_q     <= start_acq_d;
            start_reg_wrt_q <= start_reg_wrt_d;
            cfg_ack_q       <= cfg_ack_d;
            reg_cmd_q       <= reg_cmd_d;
            m_valid_q       <= m_valid_d;
            m_data_q        <= m_data_d;
            overrun_q       <= overrun_d;
            timeout_q       <= timeout_d;
        end
    end

    assign start_acq     = start_acq_q;
    assign start_reg_wrt = start_reg_wrt_q;
    assign cfg_ack       = cfg_ack_q;
    assign reg_cmd       = reg_cmd_q;
    assign m_valid       = m_valid_q;
    assign m_data        = m_data_q;
    assign overrun       = overrun_q;
    assign timeout       = timeout_q;
endmodule

// File: tb/tb_adc_acq_scheduler.sv
`timescale 1ns/1ps
// tb_adc_acq_scheduler: directed scenarios with ADC and SPI controller models
module tb_adc_acq_scheduler;
    logic        clk = 1'b0, resetn = 1'b0, enable = 1'b0, cfg_req = 1'b0;
    logic [15:0] cnv_div = 16'd100;
    logic [23:0] cfg_cmd = '0;
    logic        cfg_ack, cnv, start_acq, start_reg_wrt, m_valid, overrun, timeout;
    logic [23:0] reg_cmd;
    logic [31:0] m_data;
    logic        adc_busy, acq_done, reg_wrt_done;
    logic [31:0] cnv_data;
    logic        m_ready = 1'b1, err_clr = 1'b0;

    int n_checks = 0, n_fail = 0, cyc = 0;
    int busy_len = 20, acq_len = 5, rw_len = 4;
    logic busy_dead = 1'b0, spur = 1'b0, clr = 1'b0;
    logic [31:0] next_data = '0, data_step = '0;
    int cnv_rises, cnv_run, cnv_w, first_cnv_cyc, last_cnv_cyc, period_last;
    int sa_cnt, srw_cnt, srw_cyc, ack_cnt, ack_cyc, samp_cnt, busy_falls, adone_cyc, rwd_cyc;

    adc_acq_scheduler dut (
        .clk(clk), .resetn(resetn), .enable(enable), .cnv_div(cnv_div),
        .cfg_req(cfg_req), .cfg_cmd(cfg_cmd), .cfg_ack(cfg_ack), .cnv(cnv),
        .adc_busy(adc_busy), .start_acq(start_acq), .start_reg_wrt(start_reg_wrt),
        .reg_cmd(reg_cmd), .acq_done(acq_done), .reg_wrt_done(reg_wrt_done),
        .cnv_data(cnv_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .overrun(overrun), .timeout(timeout), .err_clr(err_clr)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // monitor and ADC / SPI controller models, all on the falling edge
    initial begin
        int acq_cnt, rw_cnt, busy_cnt;
        logic prev_cnv;
        acq_cnt = 0; rw_cnt = 0; busy_cnt = 0; prev_cnv = 1'b0;
        adc_busy = 1'b0; acq_done = 1'b0; reg_wrt_done = 1'b0; cnv_data = '0;
        cnv_rises = 0; cnv_run = 0; cnv_w = 0; first_cnv_cyc = 0; last_cnv_cyc = 0; period_last = 0;
        sa_cnt = 0; srw_cnt = 0; srw_cyc = 0; ack_cnt = 0; ack_cyc = 0; samp_cnt = 0;
        busy_falls = 0; adone_cyc = 0; rwd_cyc = 0;
        forever begin
            @(negedge clk);
            if (clr) begin
                cnv_rises = 0; cnv_w = 0; period_last = 0; sa_cnt = 0; srw_cnt = 0;
                ack_cnt = 0; samp_cnt = 0; busy_falls = 0;
            end
            if (cnv) begin
                if (cnv_run == 0) begin
                    cnv_rises++;
                    if (cnv_rises == 1) first_cnv_cyc = cyc;
                    period_last = cyc - last_cnv_cyc;
                    last_cnv_cyc = cyc;
                end
                cnv_run++;
            end else if (cnv_run > 0) begin
                cnv_w = cnv_run;
                cnv_run = 0;
            end
            if (start_acq) sa_cnt++;
            if (start_reg_wrt) begin srw_cnt++; srw_cyc = cyc; end
            if (cfg_ack) begin ack_cnt++; ack_cyc = cyc; end
            if (m_valid && m_ready) samp_cnt++;
            acq_done = spur;
            reg_wrt_done = spur;
            if (acq_cnt > 0) begin
                acq_cnt--;
                if (acq_cnt == 0) begin
                    acq_done = 1'b1;
                    cnv_data = next_data;
                    next_data = next_data + data_step;
                    adone_cyc = cyc;
                end
            end
            if (start_acq) acq_cnt = acq_len;
            if (rw_cnt > 0) begin
                rw_cnt--;
                if (rw_cnt == 0) begin reg_wrt_done = 1'b1; rwd_cyc = cyc; end
            end
            if (start_reg_wrt) rw_cnt = rw_len;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin adc_busy = 1'b0; busy_falls++; end
            end
            if (cnv && !prev_cnv && !busy_dead) begin adc_busy = 1'b1; busy_cnt = busy_len; end
            prev_cnv = cnv;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_mon();
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic test_reset();
        cycles(3);
        n_checks++;
        if ({cnv, start_acq, start_reg_wrt, cfg_ack, m_valid, overrun, timeout} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000", {cnv, start_acq, start_reg_wrt, cfg_ack, m_valid, overrun, timeout});
        end
        n_checks++;
        if (reg_cmd !== 24'h0) begin n_fail++; $display("FAIL reset_reg_cmd: got %h expected 000000", reg_cmd); end
        n_checks++;
        if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_m_data: got %h expected 00000000", m_data); end
        resetn = 1'b1;
        clr_mon();
        cycles(5);
        n_checks++;
        if (cnv_rises + sa_cnt + srw_cnt + ack_cnt + samp_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_release_pulses: got %0d expected 0", cnv_rises + sa_cnt + srw_cnt + ack_cnt + samp_cnt);
        end
    endtask

    task automatic test_periodic();
        int e;
        cnv_div = 16'd100; busy_len = 20; acq_len = 5; m_ready = 1'b1;
        next_data = 32'h8BADF00D; data_step = '0;
        clr_mon();
        e = cyc;
        enable = 1'b1;
        cycles(350);
        enable = 1'b0;
        cycles(60);
        n_checks++;
        if (cnv_rises !== 4) begin n_fail++; $display("FAIL periodic_cnv_count: got %0d expected 4", cnv_rises); end
        n_checks++;
        if (first_cnv_cyc - e !== 2) begin n_fail++; $display("FAIL periodic_first_tick: got %0d expected 2", first_cnv_cyc - e); end
        n_checks++;
        if (period_last !== 100) begin n_fail++; $display("FAIL periodic_period: got %0d expected 100", period_last); end
        n_checks++;
        if (cnv_w !== 2) begin n_fail++; $display("FAIL periodic_cnv_width: got %0d expected 2", cnv_w); end
        n_checks++;
        if (sa_cnt !== 4 || busy_falls !== 4) begin
            n_fail++;
            $display("FAIL periodic_start_acq: got %0d starts %0d busy falls expected 4 and 4", sa_cnt, busy_falls);
        end
        n_checks++;
        if (samp_cnt !== 4) begin n_fail++; $display("FAIL periodic_samples: got %0d expected 4", samp_cnt); end
        n_checks++;
        if (m_data !== 32'h8BADF00D) begin n_fail++; $display("FAIL periodic_m_data: got %h expected 8badf00d", m_data); end
        n_checks++;
        if ({m_valid, overrun, timeout} !== 3'b000) begin
            n_fail++;
            $display("FAIL periodic_flags: got %b expected 000", {m_valid, overrun, timeout});
        end
    endtask

    task automatic test_reg_write();
        logic got;
        enable = 1'b0; rw_len = 4; cfg_cmd = 24'h140001;
        clr_mon();
        got = 1'b0;
        cfg_req = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (cfg_ack) begin got = 1'b1; cfg_req = 1'b0; end
        end
        cfg_req = 1'b0;
        cycles(5);
        n_checks++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL reg_wr_ack_seen: got %b expected 1", got); end
        n_checks++;
        if (reg_cmd !== 24'h140001) begin n_fail++; $display("FAIL reg_wr_cmd: got %h expected 140001", reg_cmd); end
        n_checks++;
        if (srw_cnt !== 1 || ack_cnt !== 1) begin
            n_fail++;
            $display("FAIL reg_wr_pulses: got %0d starts %0d acks expected 1 and 1", srw_cnt, ack_cnt);
        end
        n_checks++;
        if (ack_cyc - rwd_cyc !== 1) begin n_fail++; $display("FAIL reg_wr_ack_latency: got %0d expected 1", ack_cyc - rwd_cyc); end
        @(negedge clk);
        #1 spur = 1'b1;
        @(negedge clk);
        #1 spur = 1'b0;
        cycles(3);
        n_checks++;
        if (ack_cnt !== 1 || m_valid !== 1'b0 || srw_cnt !== 1) begin
            n_fail++;
            $display("FAIL stray_done_ignored: got acks %0d m_valid %b starts %0d expected 1 0 1", ack_cnt, m_valid, srw_cnt);
        end
    endtask

    task automatic test_tick_vs_cfg();
        int e;
        logic got;
        cnv_div = 16'd100; busy_len = 3; acq_len = 4; rw_len = 3; m_ready = 1'b1;
        next_data = 32'h12345678; data_step = '0;
        clr_mon();
        e = cyc;
        got = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        cfg_cmd = 24'hABCDEF;
        cfg_req = 1'b1;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (i == 5) enable = 1'b0;
            if (cfg_ack) begin got = 1'b1; cfg_req = 1'b0; end
        end
        cfg_req = 1'b0;
        enable = 1'b0;
        cycles(5);
        n_checks++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL tick_cfg_ack_seen: got %b expected 1", got); end
        n_checks++;
        if (cnv_rises !== 1 || first_cnv_cyc - e !== 2) begin
            n_fail++;
            $display("FAIL tick_cfg_conversion_first: got %0d cnv at offset %0d expected 1 at 2", cnv_rises, first_cnv_cyc - e);
        end
        n_checks++;
        if (sa_cnt !== 1 || samp_cnt !== 1 || m_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL tick_cfg_sample: got %0d starts %0d samples data %h expected 1 1 12345678", sa_cnt, samp_cnt, m_data);
        end
        n_checks++;
        if (!(srw_cyc > adone_cyc)) begin
            n_fail++;
            $display("FAIL tick_cfg_order: got write at %0d acq_done at %0d expected write after acq_done", srw_cyc, adone_cyc);
        end
        n_checks++;
        if (srw_cnt !== 1 || ack_cnt !== 1 || reg_cmd !== 24'hABCDEF) begin
            n_fail++;
            $display("FAIL tick_cfg_write: got %0d starts %0d acks cmd %h expected 1 1 abcdef", srw_cnt, ack_cnt, reg_cmd);
        end
    endtask

    task automatic test_overrun();
        cnv_div = 16'd10; busy_len = 3; acq_len = 8; m_ready = 1'b1; data_step = '0;
        clr_mon();
        enable = 1'b1;
        cycles(55);
        enable = 1'b0;
        cycles(30);
        n_checks++;
        if (cnv_rises !== 3 || period_last !== 20) begin
            n_fail++;
            $display("FAIL overrun_skip: got %0d conversions period %0d expected 3 period 20", cnv_rises, period_last);
        end
        n_checks++;
        if (sa_cnt !== 3 || samp_cnt !== 3) begin
            n_fail++;
            $display("FAIL overrun_samples: got %0d starts %0d samples expected 3 and 3", sa_cnt, samp_cnt);
        end
        n_checks++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_backpressure();
        cnv_div = 16'd40; busy_len = 3; acq_len = 4; m_ready = 1'b0;
        next_data = 32'h11110000; data_step = 32'h1;
        clr_mon();
        enable = 1'b1;
        cycles(45);
        n_checks++;
        if (overrun !== 1'b0 || m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first_held: got overrun %b m_valid %b expected 0 1", overrun, m_valid);
        end
        cycles(5);
        enable = 1'b0;
        cycles(20);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h11110000) begin
            n_fail++;
            $display("FAIL bp_hold: got valid %b data %h expected 1 11110000", m_valid, m_data);
        end
        n_checks++;
        if (overrun !== 1'b1 || sa_cnt !== 2) begin
            n_fail++;
            $display("FAIL bp_drop: got overrun %b starts %0d expected 1 2", overrun, sa_cnt);
        end
        m_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0 || m_data !== 32'h11110000) begin
            n_fail++;
            $display("FAIL bp_drain: got valid %b data %h expected 0 11110000", m_valid, m_data);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_timeout();
        cnv_div = 16'd200; busy_dead = 1'b1;
        clr_mon();
        enable = 1'b1;
        cycles(5);
        enable = 1'b0;
        cycles(55);
        err_clr = 1'b1;
        cycles(7);
        n_checks++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", timeout); end
        cycles(1);
        n_checks++;
        if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_set_wins: got %b expected 1", timeout); end
        err_clr = 1'b0;
        cycles(2);
        n_checks++;
        if (timeout !== 1'b1 || sa_cnt !== 0 || cnv !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_sticky: got timeout %b starts %0d cnv %b expected 1 0 0", timeout, sa_cnt, cnv);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b expected 0", timeout); end
        busy_dead = 1'b0;
    endtask

    task automatic test_reset_mid_acq();
        cnv_div = 16'd100; busy_len = 3; acq_len = 20; m_ready = 1'b1;
        clr_mon();
        enable = 1'b1;
        cycles(10);
        n_checks++;
        if (sa_cnt !== 1) begin n_fail++; $display("FAIL rst_acq_started: got %0d expected 1", sa_cnt); end
        #1 resetn = 1'b0;
        #1;
        n_checks++;
        if ({cnv, start_acq, start_reg_wrt, cfg_ack, m_valid, overrun, timeout} !== 7'b0 || reg_cmd !== 24'h0 || m_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_async_outputs: got flags %b cmd %h data %h expected all zero",
                     {cnv, start_acq, start_reg_wrt, cfg_ack, m_valid, overrun, timeout}, reg_cmd, m_data);
        end
        enable = 1'b0;
        cycles(3);
        resetn = 1'b1;
        cycles(30);
        n_checks++;
        if ({cnv, m_valid, overrun, timeout} !== 4'b0 || sa_cnt !== 1 || ack_cnt !== 0 || cnv_rises !== 1) begin
            n_fail++;
            $display("FAIL rst_aborted: got flags %b starts %0d acks %0d cnv %0d expected 0000 1 0 1",
                     {cnv, m_valid, overrun, timeout}, sa_cnt, ack_cnt, cnv_rises);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_reg_write();
        test_tick_vs_cfg();
        test_overrun();
        test_backpressure();
        test_timeout();
        test_reset_mid_acq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
